// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: shared miss-fill controller, N cache channels to one pipelined read port.
// Define CACHE_FILL_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module cache_fill_ctrl #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        miss,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
    output logic [DATA_W-1:0]        fill_data,
    output logic [ADDR_W-1:0]        fill_addr,
    output logic [NUM_CH-1:0]        data_we,
    output logic [NUM_CH-1:0]        meta_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_en,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_vld,
    output logic                     stall,
    output logic                     idle
);

    localparam int STRIDE = DATA_W / 8;
    localparam int CW     = $clog2(BLK_WORDS) + 1;
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W  = $clog2(BLK_WORDS * STRIDE);

    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(STRIDE);
    localparam logic [CW-1:0]     LAST      = CW'(BLK_WORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     iss_q, iss_d;
    logic [CW-1:0]     rcv_q, rcv_d;

    logic [GW-1:0]     arb_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic              any_miss;
    logic              grant;
    logic              busy;

    assign any_miss = |miss;

`ifdef CACHE_FILL_RR_EN
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] hi_sel, lo_sel;
    logic          hi_found;

    // Round-robin: first requester above the last grant, else wrap to the lowest one.
    always_comb begin
        hi_sel   = '0;
        lo_sel   = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (miss[i]) begin
                lo_sel = GW'(i);
                if (i > int'(rr_q)) begin
                    hi_sel   = GW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        arb_sel = hi_found ? hi_sel : lo_sel;
    end

    // Pointer follows every grant.
    always_comb begin
        rr_d = grant ? arb_sel : rr_q;
    end

    // Pointer register starts so that channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= GW'(NUM_CH - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        arb_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (miss[i]) begin
                arb_sel = GW'(i);
            end
        end
    end
`endif

    // Pick the winning channel's miss address.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_sel == GW'(i)) begin
                sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Fill sequencing, issue/return counters and output strobes.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        base_d    = base_q;
        iss_d     = iss_q;
        rcv_d     = rcv_q;
        grant     = 1'b0;
        busy      = 1'b0;
        idle      = 1'b0;
        stall     = 1'b1;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_data = '0;
        fill_addr = '0;
        data_we   = '0;
        meta_we   = '0;

        unique case (state_q)
            S_IDLE: begin
                idle  = 1'b1;
                stall = any_miss;
                grant = any_miss;
            end
            S_ISSUE: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = base_q + ADDR_W'(iss_q) * STEP;
                iss_d    = iss_q + CW'(1);
                if (iss_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                if (any_miss) begin
                    grant = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (busy) begin
            fill_data = mem_rdata;
        end

        // A returned word always wins over the ISSUE->DRAIN step.
        if (busy && mem_vld) begin
            data_we   = NUM_CH'(1) << gnt_q;
            fill_addr = base_q + ADDR_W'(rcv_q) * STEP;
            rcv_d     = rcv_q + CW'(1);
            if (rcv_q == LAST) begin
                meta_we = NUM_CH'(1) << gnt_q;
                state_d = S_DONE;
            end
        end

        if (grant) begin
            gnt_d   = arb_sel;
            base_d  = sel_addr & BASE_MASK;
            iss_d   = '0;
            rcv_d   = '0;
            state_d = S_ISSUE;
        end
    end

    // State registers; reset aborts any fill in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            base_q  <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for cache_fill_ctrl with a latency/bubble memory model.
// Expected issue addresses and fill writes are queued when a miss is driven.
module tb_cache_fill_ctrl;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  miss = 2'b00;
    logic [31:0] miss_addr = 32'h0;
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic [1:0]  data_we;
    logic [1:0]  meta_we;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_vld = 1'b0;
    logic        stall;
    logic        idle;

    always #5 clk = ~clk;

    cache_fill_ctrl #(
        .NUM_CH(2),
        .ADDR_W(16),
        .DATA_W(16),
        .BLK_WORDS(BW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .miss(miss),
        .miss_addr(miss_addr),
        .fill_data(fill_data),
        .fill_addr(fill_addr),
        .data_we(data_we),
        .meta_we(meta_we),
        .mem_addr(mem_addr),
        .mem_en(mem_en),
        .mem_rdata(mem_rdata),
        .mem_vld(mem_vld),
        .stall(stall),
        .idle(idle)
    );

    typedef struct {
        logic [1:0]  we;
        logic [1:0]  meta;
        logic [15:0] addr;
        logic [15:0] data;
    } fill_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    fill_t       exp_f[$];
    logic [15:0] exp_ma[$];
    rd_t         mq[$];
    int          meta_c[$];

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 4;
    int bub = 0;
    int bub_at = 0;
    int bub_len = 0;
    int rcvd = 0;
    int rst_at_we = 0;
    bit stale = 1'b0;
    int first_en, last_en, stall_n, idle_n, we_n;
    logic [1:0] last_meta;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a * 16'd3) ^ 16'hC35A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        first_en = -1;
        last_en = -1;
        stall_n = 0;
        idle_n = 0;
        we_n = 0;
        meta_c.delete();
    endtask

    task automatic expect_fill(input int ch, input logic [15:0] a);
        logic [15:0] b;
        logic [15:0] w;
        logic [1:0]  m;
        fill_t       f;
        b = a & 16'hFFF0;
        m = (ch == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < BW; i++) begin
            w = b + 16'(2 * i);
            exp_ma.push_back(w);
            f.we = m;
            f.meta = (i == BW - 1) ? m : 2'b00;
            f.addr = w;
            f.data = mdata(w);
            exp_f.push_back(f);
        end
    endtask

    task automatic monitor();
        fill_t f;
        rd_t   r;
        last_meta = meta_we;
        if (stall === 1'b1) stall_n++;
        if (idle === 1'b1) begin
            idle_n++;
            check("idle_strobes", 32'({data_we, meta_we, mem_en}), 32'h0);
            check("idle_fill", {fill_data, fill_addr}, 32'h0);
        end
        if (mem_en === 1'b1) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (exp_ma.size() == 0) check("mem_en_extra", 32'(mem_en), 32'h0);
            else check("mem_addr", 32'(mem_addr), 32'(exp_ma.pop_front()));
            r.addr = mem_addr;
            r.due = cyc + lat;
            mq.push_back(r);
        end
        if ((|{data_we, meta_we}) === 1'b1) begin
            if (data_we !== 2'b00) we_n++;
            if (meta_we !== 2'b00) meta_c.push_back(cyc);
            if (exp_f.size() == 0) begin
                check("we_extra", 32'({data_we, meta_we}), 32'h0);
            end else begin
                f = exp_f.pop_front();
                check("data_we", 32'(data_we), 32'(f.we));
                check("meta_we", 32'(meta_we), 32'(f.meta));
                check("fill_addr", 32'(fill_addr), 32'(f.addr));
                check("fill_data", 32'(fill_data), 32'(f.data));
            end
        end
        if (rst_at_we != 0 && we_n == rst_at_we) begin
            rst = 1'b1;
            exp_f.delete();
            exp_ma.delete();
            rst_at_we = 0;
        end
    endtask

    task automatic tick();
        rd_t r;
        bit  re;
        mem_vld = 1'b0;
        mem_rdata = 16'h0;
        if (bub > 0) begin
            bub--;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            mem_vld = 1'b1;
            mem_rdata = mdata(r.addr);
            rcvd++;
            if (rcvd == bub_at) bub = bub_len;
        end
        if (stale) begin
            mem_vld = 1'b1;
            mem_rdata = 16'hDEAD;
        end
        #1;
        monitor();
        re = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (re) begin
            mq.delete();
            bub = 0;
        end
    endtask

    task automatic run(input int max, input bit auto_clr, input int stop_meta);
        for (int i = 0; i < max; i++) begin
            tick();
            if (auto_clr) miss = miss & ~last_meta;
            if (stop_meta > 0 && meta_c.size() >= stop_meta) miss = 2'b00;
            if (idle === 1'b1 && exp_f.size() == 0 && exp_ma.size() == 0) return;
        end
        check("timeout", 32'h1, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        miss = 2'b00;
        stale = 1'b0;
        lat = 4;
        bub_at = 0;
        bub_len = 0;
        rcvd = 0;
        exp_f.delete();
        exp_ma.delete();
        tick();
        tick();
        rst = 1'b0;
        clr_stats();
    endtask

    task automatic chk_time(input string t, input int c0, input int fe,
                            input int le, input int mc, input int st);
        check({t, "_first_en"}, 32'(first_en - c0), 32'(fe));
        check({t, "_last_en"}, 32'(last_en - c0), 32'(le));
        check({t, "_meta_cyc"},
              (meta_c.size() > 0) ? 32'(meta_c[$] - c0) : 32'hFFFF_FFFF,
              32'(mc));
        check({t, "_stall_n"}, 32'(stall_n), 32'(st));
    endtask

    task automatic single(input int ch, input logic [15:0] a, input string t,
                          input int mc, input int st);
        int c0;
        clr_stats();
        c0 = cyc;
        if (ch == 0) miss_addr = {16'h0, a};
        else miss_addr = {a, 16'h0};
        miss = (ch == 0) ? 2'b01 : 2'b10;
        expect_fill(ch, a);
        tick();
        miss = 2'b00;
        run(60, 1'b0, 0);
        chk_time(t, c0, 1, 8, mc, st);
        check({t, "_we_n"}, 32'(we_n), 32'(BW));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int c0;
        clr_stats();

        rst = 1'b1;
        miss = 2'b01;
        tick();
        tick();
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_strobes", 32'({data_we, meta_we, mem_en}), 32'h0);
        check("rst_outs", {fill_data, fill_addr}, 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_stall_miss", 32'(stall), 32'h1);
        miss = 2'b00;
        #1;
        check("rst_stall_nomiss", 32'(stall), 32'h0);

        do_reset();
        single(1, 16'h1236, "dmiss", 12, 14);

        do_reset();
        c0 = cyc;
        miss_addr = {16'h2000, 16'h0040};
        miss = 2'b11;
        expect_fill(0, 16'h0040);
        expect_fill(1, 16'h2000);
        run(80, 1'b1, 0);
        chk_time("both", c0, 1, 21, 25, 27);
        check("both_meta0", (meta_c.size() > 0) ? 32'(meta_c[0] - c0) : 32'hFFFF_FFFF, 32'd12);
        check("both_idle_n", 32'(idle_n), 32'd1);

        do_reset();
        c0 = cyc;
        miss_addr = {16'h0200, 16'h0100};
        miss = 2'b11;
`ifdef CACHE_FILL_RR_EN
        expect_fill(0, 16'h0100);
        expect_fill(1, 16'h0200);
        expect_fill(0, 16'h0100);
`else
        expect_fill(0, 16'h0100);
        expect_fill(0, 16'h0100);
        expect_fill(0, 16'h0100);
`endif
        run(120, 1'b0, 3);
        chk_time("cont", c0, 1, 34, 38, 40);
        check("cont_idle_n", 32'(idle_n), 32'd1);

        do_reset();
        bub_at = 4;
        bub_len = 2;
        rcvd = 0;
        single(0, 16'h3456, "bubble", 14, 16);
        bub_at = 0;

        do_reset();
        lat = 1;
        single(1, 16'h0A0A, "lat1", 9, 11);

        do_reset();
        single(0, 16'hFFF2, "wrap", 12, 14);

        do_reset();
        miss_addr = {16'h4444, 16'h0};
        miss = 2'b10;
        expect_fill(1, 16'h4444);
        rst_at_we = 5;
        tick();
        miss = 2'b00;
        for (int i = 0; i < 40 && rst !== 1'b1; i++) tick();
        check("abort_rst", 32'(rst), 32'h1);
        check("abort_idle", 32'(idle), 32'h1);
        check("abort_strobes", 32'({data_we, meta_we, mem_en}), 32'h0);
        check("abort_meta_n", 32'(meta_c.size()), 32'h0);
        check("abort_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        stale = 1'b1;
        repeat (3) tick();
        stale = 1'b0;
        check("stale_we_n", 32'(we_n), 32'd5);
        single(1, 16'h4444, "refill", 12, 14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised miss-fill controller shared by up to NUM_CH cache channels (I-cache, D-cache, …) in front of a single pipelined memory port. It arbitrates pending misses, issues one read per word of the missing block, and steers returned words into the granted cache's data array. It writes that cache's metadata with the last word and holds the pipeline stall until the fill completes. It generalises the two-channel fixed-priority fill controller to N channels, arbitrary block/data/address widths, variable memory return spacing and optional round-robin arbitration.

## Interface
- NUM_CH, 2, number of cache channels (≥1); channel 0 = I-cache, 1 = D-cache
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width (multiple of 8); STRIDE = DATA_W/8 bytes
- BLK_WORDS, 8, words per block (power of 2, ≥2)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- miss  in  NUM_CH  per-channel miss request (level)
- miss_addr  in  NUM_CH*ADDR_W  per-channel miss address; channel k at [k*ADDR_W +: ADDR_W]
- fill_data  out  DATA_W  returned word; mem_rdata while busy, else 0
- fill_addr  out  ADDR_W  cache write address of fill_data, else 0
- data_we  out  NUM_CH  data-array write strobe, granted bit only
- meta_we  out  NUM_CH  metadata (tag/valid) write strobe, granted bit only
- mem_addr  out  ADDR_W  memory read address
- mem_en  out  1  memory read issue, one word per cycle
- mem_rdata  in  DATA_W  memory read data
- mem_vld  in  1  mem_rdata valid, in issue order
- stall  out  1  pipeline stall
- idle  out  1  FSM in IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: idle=1; stall=|miss. If |miss, select grant g, latch base = miss_addr[g] with low log2(BLK_WORDS*STRIDE) bits cleared, clear iss_cnt/rcv_cnt, go to ISSUE.
- ISSUE: mem_en=1, mem_addr = base + iss_cnt*STRIDE; iss_cnt++ each cycle. After issuing word BLK_WORDS-1, go to DRAIN. This transition is skipped if the final word is also received that cycle.
- Every cycle in ISSUE/DRAIN with mem_vld: data_we[g]=1, fill_data=mem_rdata, fill_addr = base + rcv_cnt*STRIDE, rcv_cnt++.
- Last word (rcv_cnt==BLK_WORDS-1 and mem_vld): meta_we[g]=1 in the same cycle; go to DONE.
- DONE: stall=1, no strobes. If |miss, re-arbitrate and go to ISSUE (same as IDLE exit); else go to IDLE.
- stall=1 in ISSUE, DRAIN, DONE.
- Grant and base are frozen for the fill; miss/miss_addr changes mid-fill are ignored.
- mem_vld outside ISSUE/DRAIN is ignored. Memory shares rst and discards in-flight reads.
- Address arithmetic wraps modulo 2^ADDR_W. iss_cnt/rcv_cnt are log2(BLK_WORDS)+1 bits; saturation is not required because the FSM leaves on terminal counts.

## Timing
- Reset: state IDLE, counters 0, RR pointer = NUM_CH-1. Outputs: idle=1, mem_en=0, data_we=0, meta_we=0, fill_*=0, mem_addr=0, stall=|miss.
- Reset mid-fill aborts at the next edge with no further strobes. The metadata is not written, so the cache re-misses.
- Miss seen at cycle 0 in IDLE: mem_en in cycles 1..BLK_WORDS. With memory latency L and no bubbles, data_we in cycles 1+L..BLK_WORDS+L, meta_we in cycle BLK_WORDS+L, DONE in cycle BLK_WORDS+L+1.
- Penalty = BLK_WORDS+L+2 cycles; 14 with defaults and L=4.
- mem_vld bubbles only stretch DRAIN; ordering is preserved.

## Configuration
- CACHE_FILL_RR_EN defined: round-robin arbitration. The search starts at (last_grant+1) mod NUM_CH, and last_grant updates on each grant.
- CACHE_FILL_RR_EN undefined: fixed priority, lowest index wins, so the I-cache beats the D-cache. The pointer logic is absent.

## Test plan
- Single D miss, miss_addr[1]=0x1236, L=4 → mem_addr 0x1230,0x1232…0x123E. data_we[1] for 8 cycles with fill_addr matching. meta_we[1] with last word. stall 14 cycles. data_we[0] never set.
- miss=2'b11 in IDLE, addrs 0x0040/0x2000 → channel 0 filled first. DONE goes directly to ISSUE for channel 1 with no IDLE cycle.
- With CACHE_FILL_RR_EN, both channels missing continuously → grants alternate 0,1,0,1. Without the macro → channel 0 wins every arbitration.
- mem_vld with a 2-cycle bubble after word 3 → stays in DRAIN. Words 4–7 land at 0x…8–0x…E. meta_we delays by 2 cycles.
- rst asserted after the 5th data_we → next cycle idle=1, all strobes 0. Later stale mem_vld pulses are ignored. A new miss then fills correctly from word 0.
- miss_addr=0xFFF2 → mem_addr 0xFFF0…0xFFFE, with no wrap past block and none beyond 0xFFFE.
